// File: rtl/axi_rd_arb.sv
// axi_rd_arb: two-requester round-robin arbiter in front of a single-beat
// AXI-style read channel. A granted read address is registered and held
// toward memory until accepted. An in-order routing FIFO remembers which
// requester owns each outstanding read, so every returning R beat is steered
// back to its owner.
module axi_rd_arb #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   // requester 0 address channel
   input  logic                  i_s0_ar_vld,
   input  logic [ADDR_WIDTH-1:0] i_s0_ar_addr,
   output logic                  o_s0_ar_rdy,
   // requester 1 address channel
   input  logic                  i_s1_ar_vld,
   input  logic [ADDR_WIDTH-1:0] i_s1_ar_addr,
   output logic                  o_s1_ar_rdy,
   // memory address channel
   output logic                  o_m_ar_vld,
   output logic [ADDR_WIDTH-1:0] o_m_ar_addr,
   input  logic                  i_m_ar_rdy,
   // memory data channel
   input  logic                  i_m_r_vld,
   input  logic [DATA_WIDTH-1:0] i_m_r_data,
   output logic                  o_m_r_rdy,
   // requester data channels (data bus is shared)
   output logic                  o_s0_r_vld,
   output logic                  o_s1_r_vld,
   output logic [DATA_WIDTH-1:0] o_s_r_data,
   input  logic                  i_s0_r_rdy,
   input  logic                  i_s1_r_rdy,
   // status
   output logic                  o_busy,
   output logic                  o_err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   state_e                  state_q, state_d;
   logic                    m_ar_vld_q, m_ar_vld_d;
   logic [ADDR_WIDTH-1:0]   m_ar_addr_q, m_ar_addr_d;
   logic                    last_grant_q, last_grant_d;
   logic                    err_q, err_d;
   logic [CNT_W-1:0]        count_q, count_d;
   logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
   // One owner bit per outstanding read: 0 = requester 0, 1 = requester 1.
   logic [DEPTH-1:0]        owner_q, owner_d;

   // ---------------------------------------------------------------------
   // Internal combinational signals
   // ---------------------------------------------------------------------
   logic grant_ok;
   logic push;
   logic winner;
   logic pop;
   logic ne;
   logic head;

   // Routing FIFO status: head owner and non-empty flag.
   always_comb begin
      ne   = (count_q != '0);
      head = owner_q[rd_ptr_q];
   end

   // R channel steering: only the head owner sees valid, and only its ready
   // can release memory. Nothing is accepted while no read is outstanding.
   always_comb begin
      o_s_r_data = i_m_r_data;
      o_s0_r_vld = i_m_r_vld & ne & (head == 1'b0);
      o_s1_r_vld = i_m_r_vld & ne & (head == 1'b1);
      o_m_r_rdy  = ne & (head ? i_s1_r_rdy : i_s0_r_rdy);
      pop        = i_m_r_vld & o_m_r_rdy;
   end

   // Arbitration FSM next-state and requester ready outputs. A full FIFO
   // blocks the grant even if a pop happens in the same cycle.
   always_comb begin
      // NOTE: every signal driven here gets a default first so that no path
      // through the case leaves it unassigned, which would infer a latch.
      state_d      = state_q;
      m_ar_vld_d   = m_ar_vld_q;
      m_ar_addr_d  = m_ar_addr_q;
      last_grant_d = last_grant_q;
      push         = 1'b0;
      winner       = 1'b0;
      o_s0_ar_rdy  = 1'b0;
      o_s1_ar_rdy  = 1'b0;
      grant_ok     = (count_q < FULL_CNT);

      unique case (state_q)
         IDLE: begin
            if (grant_ok && (i_s0_ar_vld || i_s1_ar_vld)) begin
               // On a tie the requester that did not win last time goes next.
               if (i_s0_ar_vld && i_s1_ar_vld) begin
                  winner = ~last_grant_q;
               end else begin
                  winner = i_s1_ar_vld;
               end
               push         = 1'b1;
               o_s0_ar_rdy  = ~winner;
               o_s1_ar_rdy  = winner;
               m_ar_vld_d   = 1'b1;
               m_ar_addr_d  = winner ? i_s1_ar_addr : i_s0_ar_addr;
               last_grant_d = winner;
               state_d      = BUSY;
            end
         end
         BUSY: begin
            // Address is held stable until memory takes it.
            if (i_m_ar_rdy) begin
               m_ar_vld_d = 1'b0;
               state_d    = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Routing FIFO bookkeeping: push the winner, pop on an accepted R beat,
   // and flag R beats that arrive with nothing outstanding.
   always_comb begin
      owner_d  = owner_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
      err_d    = err_q | (i_m_r_vld & ~ne);
      if (push) begin
         owner_d[wr_ptr_q] = winner;
         wr_ptr_d          = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   // State registers; reset discards every pending and outstanding read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         m_ar_vld_q   <= 1'b0;
         m_ar_addr_q  <= '0;
         last_grant_q <= 1'b1;
         err_q        <= 1'b0;
         count_q      <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         owner_q      <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values, independent of statement order.
         state_q      <= state_d;
         m_ar_vld_q   <= m_ar_vld_d;
         m_ar_addr_q  <= m_ar_addr_d;
         last_grant_q <= last_grant_d;
         err_q        <= err_d;
         count_q      <= count_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         owner_q      <= owner_d;
      end
   end

   // Registered and status outputs.
   always_comb begin
      o_m_ar_vld  = m_ar_vld_q;
      o_m_ar_addr = m_ar_addr_q;
      o_err       = err_q;
      o_busy      = (state_q == BUSY) | ne;
   end

endmodule

// File: tb/tb_axi_rd_arb.sv
// Directed bench for axi_rd_arb: single grant, round-robin ties, full FIFO,
// address backpressure, data backpressure, spurious data and mid-run reset.
module tb_axi_rd_arb;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_s0_ar_vld, i_s1_ar_vld;
   logic [AW-1:0] i_s0_ar_addr, i_s1_ar_addr;
   logic          o_s0_ar_rdy, o_s1_ar_rdy;
   logic          o_m_ar_vld;
   logic [AW-1:0] o_m_ar_addr;
   logic          i_m_ar_rdy;
   logic          i_m_r_vld;
   logic [DW-1:0] i_m_r_data;
   logic          o_m_r_rdy;
   logic          o_s0_r_vld, o_s1_r_vld;
   logic [DW-1:0] o_s_r_data;
   logic          i_s0_r_rdy, i_s1_r_rdy;
   logic          o_busy, o_err;

   int errors = 0;
   int checks = 0;

   axi_rd_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_s0_ar_vld  (i_s0_ar_vld),
      .i_s0_ar_addr (i_s0_ar_addr),
      .o_s0_ar_rdy  (o_s0_ar_rdy),
      .i_s1_ar_vld  (i_s1_ar_vld),
      .i_s1_ar_addr (i_s1_ar_addr),
      .o_s1_ar_rdy  (o_s1_ar_rdy),
      .o_m_ar_vld   (o_m_ar_vld),
      .o_m_ar_addr  (o_m_ar_addr),
      .i_m_ar_rdy   (i_m_ar_rdy),
      .i_m_r_vld    (i_m_r_vld),
      .i_m_r_data   (i_m_r_data),
      .o_m_r_rdy    (o_m_r_rdy),
      .o_s0_r_vld   (o_s0_r_vld),
      .o_s1_r_vld   (o_s1_r_vld),
      .o_s_r_data   (o_s_r_data),
      .i_s0_r_rdy   (i_s0_r_rdy),
      .i_s1_r_rdy   (i_s1_r_rdy),
      .o_busy       (o_busy),
      .o_err        (o_err)
   );

   always #5 clk = ~clk;

   // Advance past the next rising edge; inputs are driven and outputs
   // sampled inside the low-activity window that follows.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_b(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present one R beat for the current head, check routing, then pop it.
   task automatic r_beat(input string tag, input logic owner, input logic [31:0] data);
      i_m_r_vld  = 1'b1;
      i_m_r_data = data;
      #1;
      chk_b({tag, "_s0_vld"}, o_s0_r_vld, ~owner);
      chk_b({tag, "_s1_vld"}, o_s1_r_vld, owner);
      chk_b({tag, "_m_rdy"}, o_m_r_rdy, 1'b1);
      chk_w({tag, "_data"}, o_s_r_data, data);
      step();
      i_m_r_vld = 1'b0;
   endtask

   initial begin
      rst_n        = 1'b0;
      i_s0_ar_vld  = 1'b0;
      i_s1_ar_vld  = 1'b0;
      i_s0_ar_addr = '0;
      i_s1_ar_addr = '0;
      i_m_ar_rdy   = 1'b0;
      i_m_r_vld    = 1'b0;
      i_m_r_data   = '0;
      i_s0_r_rdy   = 1'b1;
      i_s1_r_rdy   = 1'b1;

      // ---- reset values ----
      repeat (2) @(posedge clk);
      #1;
      chk_b("rst_m_ar_vld", o_m_ar_vld, 1'b0);
      chk_w("rst_m_ar_addr", o_m_ar_addr, 32'h0);
      chk_b("rst_busy", o_busy, 1'b0);
      chk_b("rst_err", o_err, 1'b0);
      chk_b("rst_m_r_rdy", o_m_r_rdy, 1'b0);
      rst_n = 1'b1;
      step();

      // ---- single requester ----
      i_s0_ar_vld  = 1'b1;
      i_s0_ar_addr = 32'h100;
      i_m_ar_rdy   = 1'b1;
      #1;
      chk_b("single_s0_ar_rdy", o_s0_ar_rdy, 1'b1);
      chk_b("single_s1_ar_rdy", o_s1_ar_rdy, 1'b0);
      chk_b("single_m_vld_c0", o_m_ar_vld, 1'b0);
      step();
      i_s0_ar_vld = 1'b0;
      #1;
      chk_b("single_m_vld_c1", o_m_ar_vld, 1'b1);
      chk_w("single_m_addr_c1", o_m_ar_addr, 32'h100);
      chk_b("single_busy_ar_rdy", o_s0_ar_rdy, 1'b0);
      step();
      chk_b("single_m_vld_c2", o_m_ar_vld, 1'b0);
      chk_b("single_busy_outst", o_busy, 1'b1);
      r_beat("single_r", 1'b0, 32'hDEAD);
      chk_b("single_busy_after", o_busy, 1'b0);

      // ---- fresh reset so the first tie goes to requester 0 ----
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();

      // ---- tie round-robin, filling the FIFO ----
      i_s0_ar_vld  = 1'b1;
      i_s0_ar_addr = 32'h0;
      i_s1_ar_vld  = 1'b1;
      i_s1_ar_addr = 32'h1000;
      i_m_ar_rdy   = 1'b1;
      #1;
      chk_b("rr0_s0_rdy", o_s0_ar_rdy, 1'b1);
      chk_b("rr0_s1_rdy", o_s1_ar_rdy, 1'b0);
      step();
      chk_w("rr0_addr", o_m_ar_addr, 32'h0);
      step();
      chk_b("rr1_s0_rdy", o_s0_ar_rdy, 1'b0);
      chk_b("rr1_s1_rdy", o_s1_ar_rdy, 1'b1);
      step();
      chk_w("rr1_addr", o_m_ar_addr, 32'h1000);
      step();
      chk_b("rr2_s0_rdy", o_s0_ar_rdy, 1'b1);
      step();
      chk_w("rr2_addr", o_m_ar_addr, 32'h0);
      step();
      chk_b("rr3_s1_rdy", o_s1_ar_rdy, 1'b1);
      step();
      chk_w("rr3_addr", o_m_ar_addr, 32'h1000);
      step();
      // Four reads outstanding: both requesters still asking, none granted.
      chk_b("full_s0_rdy", o_s0_ar_rdy, 1'b0);
      chk_b("full_s1_rdy", o_s1_ar_rdy, 1'b0);
      chk_b("full_m_vld", o_m_ar_vld, 1'b0);
      step();
      chk_b("full_hold_s0_rdy", o_s0_ar_rdy, 1'b0);
      // Pop in the same cycle as the blocked request: still no grant.
      i_m_r_vld  = 1'b1;
      i_m_r_data = 32'hA000;
      #1;
      chk_b("full_pop_s0_vld", o_s0_r_vld, 1'b1);
      chk_b("full_pop_m_rdy", o_m_r_rdy, 1'b1);
      chk_b("full_pop_no_grant", o_s0_ar_rdy, 1'b0);
      chk_b("full_pop_no_grant1", o_s1_ar_rdy, 1'b0);
      step();
      i_m_r_vld = 1'b0;
      #1;
      // Next cycle the tie goes to s0 (s1 won last).
      chk_b("full_next_s0_rdy", o_s0_ar_rdy, 1'b1);
      chk_b("full_next_s1_rdy", o_s1_ar_rdy, 1'b0);
      step();
      i_s0_ar_vld = 1'b0;
      i_s1_ar_vld = 1'b0;
      chk_w("full_next_addr", o_m_ar_addr, 32'h0);
      step();
      // Remaining owners in order: s1, s0, s1, s0.
      r_beat("rr_r1", 1'b1, 32'hA001);
      r_beat("rr_r2", 1'b0, 32'hA002);
      r_beat("rr_r3", 1'b1, 32'hA003);
      r_beat("rr_r4", 1'b0, 32'hA004);
      chk_b("rr_busy_after", o_busy, 1'b0);

      // ---- AR backpressure ----
      i_m_ar_rdy   = 1'b0;
      i_s1_ar_vld  = 1'b1;
      i_s1_ar_addr = 32'h2000;
      #1;
      chk_b("bp_s1_rdy", o_s1_ar_rdy, 1'b1);
      step();
      i_s1_ar_vld  = 1'b0;
      i_s0_ar_vld  = 1'b1;
      i_s0_ar_addr = 32'h300;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk_b($sformatf("bp_vld_%0d", i), o_m_ar_vld, 1'b1);
         chk_w($sformatf("bp_addr_%0d", i), o_m_ar_addr, 32'h2000);
         chk_b($sformatf("bp_s0_rdy_%0d", i), o_s0_ar_rdy, 1'b0);
         step();
      end
      i_m_ar_rdy = 1'b1;
      step();
      chk_b("bp_accepted", o_m_ar_vld, 1'b0);
      chk_b("bp_s0_grant", o_s0_ar_rdy, 1'b1);
      step();
      i_s0_ar_vld = 1'b0;
      chk_w("bp_s0_addr", o_m_ar_addr, 32'h300);
      step();

      // ---- R backpressure: head is s1 ----
      i_s1_r_rdy = 1'b0;
      i_m_r_vld  = 1'b1;
      i_m_r_data = 32'hBEEF;
      #1;
      chk_b("rbp_s1_vld", o_s1_r_vld, 1'b1);
      chk_b("rbp_s0_vld", o_s0_r_vld, 1'b0);
      chk_b("rbp_m_rdy", o_m_r_rdy, 1'b0);
      step();
      chk_b("rbp_held_s1_vld", o_s1_r_vld, 1'b1);
      chk_b("rbp_held_m_rdy", o_m_r_rdy, 1'b0);
      i_s1_r_rdy = 1'b1;
      #1;
      chk_b("rbp_release_m_rdy", o_m_r_rdy, 1'b1);
      step();
      i_m_r_vld = 1'b0;
      r_beat("rbp_r2", 1'b0, 32'h1234);
      chk_b("rbp_busy_after", o_busy, 1'b0);
      chk_b("rbp_err_clear", o_err, 1'b0);

      // ---- spurious data ----
      i_m_r_vld  = 1'b1;
      i_m_r_data = 32'h5555;
      #1;
      chk_b("spur_m_rdy", o_m_r_rdy, 1'b0);
      chk_b("spur_s0_vld", o_s0_r_vld, 1'b0);
      chk_b("spur_s1_vld", o_s1_r_vld, 1'b0);
      step();
      i_m_r_vld = 1'b0;
      chk_b("spur_err_set", o_err, 1'b1);
      step();
      chk_b("spur_err_sticky", o_err, 1'b1);

      // ---- reset mid-stream ----
      i_m_ar_rdy   = 1'b0;
      i_s0_ar_vld  = 1'b1;
      i_s0_ar_addr = 32'h500;
      step();
      i_s0_ar_vld = 1'b0;
      chk_b("mid_m_vld_pre", o_m_ar_vld, 1'b1);
      rst_n = 1'b0;
      #1;
      chk_b("mid_err_clr", o_err, 1'b0);
      chk_b("mid_m_vld_clr", o_m_ar_vld, 1'b0);
      chk_w("mid_m_addr_clr", o_m_ar_addr, 32'h0);
      chk_b("mid_busy_clr", o_busy, 1'b0);
      step();
      rst_n     = 1'b1;
      i_m_r_vld = 1'b1;
      #1;
      chk_b("mid_no_route_s0", o_s0_r_vld, 1'b0);
      chk_b("mid_no_route_s1", o_s1_r_vld, 1'b0);
      chk_b("mid_no_m_rdy", o_m_r_rdy, 1'b0);
      step();
      i_m_r_vld = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/axi_rd_arb.md
Name: axi_rd_arb

Overview:
- Two-requester round-robin arbiter sharing one AXI-style single-beat read channel (AR + R) between two address generators, e.g. two copy-engine controllers.
- Registers the granted read address and holds it stable toward memory until it is accepted.
- Records which requester owns each outstanding read in an in-order routing FIFO, and steers each returning R beat to that requester.
- Sits between the controllers/datapath and the memory read port.

Parameters:
ADDR_WIDTH, 32, read address width
DATA_WIDTH, 32, read data width
DEPTH, 4, max outstanding reads; power of two, >= 2

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_s0_ar_vld  in  1  requester 0 read address valid
i_s0_ar_addr  in  ADDR_WIDTH  requester 0 read address
o_s0_ar_rdy  out  1  requester 0 address accepted
i_s1_ar_vld  in  1  requester 1 read address valid
i_s1_ar_addr  in  ADDR_WIDTH  requester 1 read address
o_s1_ar_rdy  out  1  requester 1 address accepted
o_m_ar_vld  out  1  memory read address valid
o_m_ar_addr  out  ADDR_WIDTH  memory read address
i_m_ar_rdy  in  1  memory read address ready
i_m_r_vld  in  1  memory read data valid
i_m_r_data  in  DATA_WIDTH  memory read data
o_m_r_rdy  out  1  memory read data ready
o_s0_r_vld  out  1  read data valid to requester 0
o_s1_r_vld  out  1  read data valid to requester 1
o_s_r_data  out  DATA_WIDTH  read data, broadcast to both requesters
i_s0_r_rdy  in  1  requester 0 data ready
i_s1_r_rdy  in  1  requester 1 data ready
o_busy  out  1  address pending or reads outstanding
o_err  out  1  sticky: R beat arrived with nothing outstanding

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Values at reset:
  - Registered state: state=IDLE, o_m_ar_vld=0, o_m_ar_addr=0, FIFO empty, count=0, o_err=0, last_grant=1 (requester 0 wins the first tie).
  - Combinational outputs: all valid/ready outputs are 0.
- Reset mid-operation: all pending and outstanding reads are discarded; no R beats are routed after reset.
- FSM, IDLE:
  - grant_ok = (count < DEPTH).
  - If grant_ok and at least one i_sK_ar_vld: select the winner. On a tie, pick the requester != last_grant; otherwise pick the sole requester.
  - Assert o_sK_ar_rdy=1 combinationally for the winner in that same cycle (the requester handshake completes there).
  - On the clock edge: latch the winner's addr into o_m_ar_addr, set o_m_ar_vld=1, push the winner index into the FIFO, count+1, last_grant=K, go to BUSY.
  - If grant_ok is false, both o_sK_ar_rdy stay 0.
- FSM, BUSY:
  - o_m_ar_vld=1 and o_m_ar_addr are held stable.
  - Both o_sK_ar_rdy are 0.
  - On i_m_ar_rdy: clear o_m_ar_vld and return to IDLE at the next edge.
- Throughput: at most one grant per two cycles. Latency from requester handshake to o_m_ar_vld is 1 cycle.
- R routing, all combinational:
  - head = FIFO head index; ne = (count != 0).
  - o_sK_r_vld = i_m_r_vld & ne & (head==K).
  - o_m_r_rdy = ne & i_s{head}_r_rdy.
  - o_s_r_data = i_m_r_data.
  - The non-head requester never sees valid. Backpressure from the head requester stalls memory.
- Pop: on i_m_r_vld & o_m_r_rdy, pop the FIFO and decrement count.
- Simultaneous push and pop in one cycle: count is unchanged and the FIFO pointers both advance.
- Full/empty:
  - FIFO full (count==DEPTH) blocks new grants, with no same-cycle pop bypass.
  - FIFO pointers are log2(DEPTH) bits and wrap naturally.
  - count is $clog2(DEPTH+1) bits.
- Spurious data: i_m_r_vld while count==0 gives o_m_r_rdy=0 and sets o_err=1 at the next edge. o_err is cleared only by reset.
- o_busy = (state==BUSY) | ne.

Test Plan:
- Single requester: s0 requests 0x100; m_ar_rdy=1 -> o_s0_ar_rdy=1 in cycle 0, o_m_ar_vld=1 with addr 0x100 in cycle 1, back in IDLE in cycle 2. An R beat with data 0xDEAD -> o_s0_r_vld=1, o_s1_r_vld=0, FIFO pops, o_busy=0 afterwards.
- Tie round-robin: both requesters hold vld continuously with addrs 0x0 and 0x1000 -> grant order s0, s1, s0, s1. R beats return to s0, s1, s0, s1 in order.
- AR backpressure: i_m_ar_rdy=0 for 5 cycles -> o_m_ar_vld and addr stay stable, no new o_sK_ar_rdy, then the address is accepted on the first i_m_ar_rdy=1.
- Full FIFO: with DEPTH=4, issue 4 grants and return no R -> the 5th request sees o_sK_ar_rdy=0 until one R pop. A pop in the same cycle as the blocked request does not grant it; it is granted in the next cycle.
- R backpressure and spurious data:
  - Head s1 holds i_s1_r_rdy=0 -> o_m_r_rdy=0, FIFO is held.
  - With the FIFO empty, i_m_r_vld=1 -> o_err=1, and it stays 1 until rst_n is asserted mid-stream, which clears all state.
